// File: rtl/spi_pkg.sv
// Shared SPI definitions: receiver FSM states and synchroniser depth.
package spi_pkg;

  typedef enum logic {
    RX_IDLE,
    RX_SHIFT
  } rx_state_t;

  localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser with an extra history flop for edge detection.
module sync_edge #(
  parameter int unsigned STAGES    = 2,
  parameter bit          RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic a_rst,
  input  logic d_i,
  output logic level_o,
  output logic edge_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign edge_o  = sync_q[STAGES-1] ^ prev_q;

endmodule

// File: rtl/spi_receiver.sv
// SPI slave receiver: oversampled sck/cs/mosi, MSB-first deserialiser,
// valid/ready output register with overrun and frame-error pulses.
module spi_receiver
  import spi_pkg::*;
#(
  parameter int unsigned p_data_width  = 8,
  parameter bit          p_cs_polar    = 1'b1,
  parameter bit          p_sample_rise = 1'b1
) (
  input  logic                    clk,
  input  logic                    a_rst,
  input  logic                    s_rst,
  input  logic                    sck,
  input  logic                    cs_n,
  input  logic                    mosi,
  output logic [p_data_width-1:0] data,
  output logic                    valid,
  input  logic                    ready,
  output logic                    busy,
  output logic                    overrun,
  output logic                    frame_err
);

  localparam int unsigned       CW   = $clog2(p_data_width);
  localparam logic [CW-1:0]     LAST = CW'(p_data_width - 1);

  logic                    sck_lvl, sck_edge, cs_lvl, cs_edge;
  logic [SYNC_STAGES-1:0]  mosi_q;
  logic                    sample, cs_assert, cs_deassert;

  rx_state_t               state_q;
  logic [p_data_width-1:0] shift_q;
  logic [CW-1:0]           cnt_q;
  logic                    done_q;
  logic [p_data_width-1:0] data_q;
  logic                    valid_q, overrun_q, ferr_q;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(!p_sample_rise)) u_sck_sync (
    .clk     (clk),
    .a_rst   (a_rst),
    .d_i     (sck),
    .level_o (sck_lvl),
    .edge_o  (sck_edge)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(p_cs_polar)) u_cs_sync (
    .clk     (clk),
    .a_rst   (a_rst),
    .d_i     (cs_n),
    .level_o (cs_lvl),
    .edge_o  (cs_edge)
  );

  // mosi gets the same depth as sck so a sample edge sees the matching bit
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) mosi_q <= '0;
    else       mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
  end

  assign sample      = sck_edge && (sck_lvl == p_sample_rise);
  assign cs_assert   = cs_edge && (cs_lvl != p_cs_polar);
  assign cs_deassert = cs_edge && (cs_lvl == p_cs_polar);

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state_q   <= RX_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else if (s_rst) begin
      state_q   <= RX_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
      done_q    <= 1'b0;

      // Completed word is handed over one cycle after the final shift
      if (done_q) begin
        if (!valid_q || ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && ready) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        RX_IDLE: begin
          cnt_q <= '0;
          if (cs_assert) state_q <= RX_SHIFT;
        end
        RX_SHIFT: begin
          if (cs_deassert) begin
            state_q <= RX_IDLE;
            ferr_q  <= (cnt_q != '0);
            cnt_q   <= '0;
            shift_q <= '0;
          end else if (sample) begin
            shift_q <= {shift_q[p_data_width-2:0], mosi_q[SYNC_STAGES-1]};
            if (cnt_q == LAST) begin
              cnt_q  <= '0;
              done_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign busy      = (state_q == RX_SHIFT);
  assign overrun   = overrun_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_spi_receiver.sv
// Scoreboard bench for spi_receiver: default instance plus an active-high-cs,
// falling-edge-sample instance sharing one logical stimulus driver.
module tb_spi_receiver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rst, s_rst, ready;
  logic sel, cs_act, sck_ph, mosi_v;

  logic sck1, cs_n1, mosi1, sck2, cs2, mosi2;
  assign sck1  = sel ? 1'b0 : sck_ph;
  assign cs_n1 = sel ? 1'b1 : ~cs_act;
  assign mosi1 = sel ? 1'b0 : mosi_v;
  assign sck2  = sel ? ~sck_ph : 1'b1;
  assign cs2   = sel ? cs_act : 1'b0;
  assign mosi2 = sel ? mosi_v : 1'b0;

  logic [7:0] data1, data2;
  logic valid1, busy1, ovr1, fe1;
  logic valid2, busy2, ovr2, fe2;

  spi_receiver #(.p_data_width(8), .p_cs_polar(1'b1), .p_sample_rise(1'b1)) dut (
    .clk(clk), .a_rst(a_rst), .s_rst(s_rst), .sck(sck1), .cs_n(cs_n1), .mosi(mosi1),
    .data(data1), .valid(valid1), .ready(ready), .busy(busy1),
    .overrun(ovr1), .frame_err(fe1)
  );

  spi_receiver #(.p_data_width(8), .p_cs_polar(1'b0), .p_sample_rise(1'b0)) dut2 (
    .clk(clk), .a_rst(a_rst), .s_rst(s_rst), .sck(sck2), .cs_n(cs2), .mosi(mosi2),
    .data(data2), .valid(valid2), .ready(1'b1), .busy(busy2),
    .overrun(ovr2), .frame_err(fe2)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp1[$];
  logic [7:0] exp2[$];
  int ovr_cnt = 0, fe_cnt = 0, fe_cyc = 0, cs_cyc = 0, last_edge = 0;
  int val2_cnt = 0, bad2_cnt = 0;
  logic valid1_prev = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected words on every accepted output
  always @(negedge clk) begin
    if (valid1 && ready) begin
      if (exp1.size() == 0) check("dut1_unexpected_word", 32'(data1), -1);
      else                  check("dut1_data", 32'(data1), 32'(exp1.pop_front()));
    end
    if (valid1 && !valid1_prev) check("dut1_valid_latency", cyc - last_edge, 4);
    valid1_prev <= valid1;
    if (ovr1) ovr_cnt <= ovr_cnt + 1;
    if (fe1) begin
      fe_cnt <= fe_cnt + 1;
      fe_cyc <= cyc;
    end
    if (valid2) begin
      val2_cnt <= val2_cnt + 1;
      if (exp2.size() == 0) check("dut2_unexpected_word", 32'(data2), -1);
      else                  check("dut2_data", 32'(data2), 32'(exp2.pop_front()));
    end
    if (ovr2 || fe2) bad2_cnt <= bad2_cnt + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      mosi_v = b[7-i];
      step(4);
      sck_ph = 1'b1;
      last_edge = cyc;
      step(4);
      sck_ph = 1'b0;
    end
  endtask

  task automatic cs_on();
    cs_act = 1'b1;
    step(4);
  endtask

  task automatic cs_off();
    step(4);
    cs_act = 1'b0;
    cs_cyc = cyc;
    step(8);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst = 1'b1; s_rst = 1'b0; ready = 1'b1;
    sel = 1'b0; cs_act = 1'b0; sck_ph = 1'b0; mosi_v = 1'b0;
    step(3);
    check("rst_data", 32'(data1), 0);
    check("rst_valid", 32'(valid1), 0);
    check("rst_busy", 32'(busy1), 0);
    check("rst_overrun", 32'(ovr1), 0);
    check("rst_frame_err", 32'(fe1), 0);
    a_rst = 1'b0;
    step(4);

    // Single word
    exp1.push_back(8'hA5);
    cs_on();
    send_bits(8'hA5, 8);
    cs_off();
    check("single_drained", exp1.size(), 0);
    check("single_no_ferr", fe_cnt, 0);
    check("single_no_ovr", ovr_cnt, 0);

    // Back-to-back words in one frame
    exp1.push_back(8'h3C);
    exp1.push_back(8'hC3);
    cs_on();
    check("b2b_busy_start", 32'(busy1), 1);
    send_bits(8'h3C, 8);
    check("b2b_busy_mid", 32'(busy1), 1);
    send_bits(8'hC3, 8);
    check("b2b_busy_end", 32'(busy1), 1);
    cs_off();
    check("b2b_busy_after", 32'(busy1), 0);
    check("b2b_drained", exp1.size(), 0);

    // Backpressure: second word dropped with one overrun
    ready = 1'b0;
    exp1.push_back(8'h11);
    cs_on();
    send_bits(8'h11, 8);
    send_bits(8'h22, 8);
    cs_off();
    check("bp_data_held", 32'(data1), 32'h11);
    check("bp_valid_held", 32'(valid1), 1);
    check("bp_overrun_cnt", ovr_cnt, 1);
    ready = 1'b1;
    step(2);
    check("bp_valid_cleared", 32'(valid1), 0);
    check("bp_drained", exp1.size(), 0);
    check("bp_overrun_once", ovr_cnt, 1);

    // Abort after 5 bits, then a clean frame
    cs_on();
    send_bits(8'hFF, 5);
    cs_off();
    check("abort_ferr_cnt", fe_cnt, 1);
    check("abort_ferr_latency", fe_cyc - cs_cyc, 3);
    check("abort_no_valid", 32'(valid1), 0);
    exp1.push_back(8'h81);
    cs_on();
    send_bits(8'h81, 8);
    cs_off();
    check("recover_drained", exp1.size(), 0);
    check("recover_no_ferr", fe_cnt, 1);

    // Async reset while a word is pending
    ready = 1'b0;
    cs_on();
    send_bits(8'h77, 8);
    cs_off();
    check("arst_pre_data", 32'(data1), 32'h77);
    check("arst_pre_valid", 32'(valid1), 1);
    a_rst = 1'b1;
    #1;
    check("arst_data", 32'(data1), 0);
    check("arst_valid", 32'(valid1), 0);
    check("arst_busy", 32'(busy1), 0);
    step(2);
    a_rst = 1'b0;
    step(10);
    check("arst_post_valid", 32'(valid1), 0);
    check("arst_post_ovr", ovr_cnt, 1);
    check("arst_post_ferr", fe_cnt, 1);

    // Sync clear while a word is pending
    cs_on();
    send_bits(8'h42, 8);
    cs_off();
    check("srst_pre_valid", 32'(valid1), 1);
    s_rst = 1'b1;
    step(1);
    s_rst = 1'b0;
    check("srst_valid", 32'(valid1), 0);
    check("srst_data", 32'(data1), 0);
    ready = 1'b1;
    step(3);

    // sck activity with cs inactive on the default instance
    for (int i = 0; i < 16; i++) begin
      sck_ph = ~sck_ph;
      mosi_v = 1'(i);
      step(4);
    end
    check("idle_sck_busy1", 32'(busy1), 0);
    check("idle_sck_valid1", 32'(valid1), 0);
    check("idle_sck_ferr1", fe_cnt, 1);

    // Second instance: active-high cs, falling-edge sampling
    sel = 1'b1;
    sck_ph = 1'b0;
    step(6);
    exp2.push_back(8'h5A);
    cs_on();
    check("pol_busy2", 32'(busy2), 1);
    send_bits(8'h5A, 8);
    cs_off();
    check("pol_drained", exp2.size(), 0);
    check("pol_word_count", val2_cnt, 1);
    for (int i = 0; i < 16; i++) begin
      sck_ph = ~sck_ph;
      mosi_v = 1'b1;
      step(4);
    end
    check("pol_idle_busy2", 32'(busy2), 0);
    check("pol_idle_words", val2_cnt, 1);
    check("pol_no_pulses", bad2_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_receiver.md
# spi_receiver

Deserialising SPI receiver that consumes the serial stream (sck, cs_n, mosi) produced by the team's transmitter. It oversamples all three lines in the local clock domain, shifts in MSB-first words of p_data_width bits and presents each completed word on a valid/ready output port. It flags overrun when the consumer stalls and frame errors when chip-select drops mid-word. It is the loopback/verification partner of the transmitter and the entry point for any SPI-slave datapath.

## Interface
- p_data_width, 8: bits per word, ≥2.
- p_cs_polar, 1: 1 = cs_n active low; 0 = cs_n active high. Must match the transmitter's setting.
- p_sample_rise, 1: 1 = sample mosi on rising sck; 0 = on falling sck.
- clk  in  1  system clock.
- a_rst  in  1  asynchronous reset, active high.
- s_rst  in  1  synchronous clear, active high; same effect as a_rst, taken at the clk edge.
- sck  in  1  serial clock, asynchronous to clk.
- cs_n  in  1  chip select, polarity per p_cs_polar.
- mosi  in  1  serial data.
- data  out  p_data_width  received word, valid while valid=1.
- valid  out  1  word available.
- ready  in  1  consumer accepts the word when valid&&ready at a clk edge.
- busy  out  1  a frame is active (synchronised cs asserted).
- overrun  out  1  one-cycle pulse: a word was completed while valid&&!ready; the new word is dropped.
- frame_err  out  1  one-cycle pulse: cs deasserted with 1..p_data_width-1 bits shifted.

## Operation
- sck, cs_n, mosi each pass a 2-flop synchroniser of identical depth, so the three lines stay aligned. A third register on sck and cs provides edge detection.
- States:
  - IDLE: cs inactive. Bit counter is 0. Enters SHIFT on synchronised cs assert.
  - SHIFT: on each detected sample edge, shift reg = {shift[W-2:0], mosi_sync} and bit_cnt++. When bit_cnt reaches W-1 on a sample edge, the word is complete: load the output register (or pulse overrun), clear bit_cnt and stay in SHIFT so back-to-back words in one frame are supported. Goes to IDLE on cs deassert.
- On cs deassert with bit_cnt≠0: pulse frame_err and discard the partial word. On cs deassert with bit_cnt=0: no error.
- A sample edge in the same cycle as a cs deassert is ignored.
- Output register:
  - valid sets on word completion if valid=0, or if valid&&ready in that same cycle. In the latter case the old word is consumed and the new one loaded, with no overrun.
  - valid clears on valid&&ready with no simultaneous completion.
  - data is stable while valid=1.
- sck edges while cs is inactive are ignored.
- bit_cnt width is $clog2(p_data_width). No wrap beyond W-1.
- a_rst or s_rst at any time, including mid-frame or with valid=1: return to IDLE, clear the shift register, bit_cnt and the output register, and drop the pending word.

## Timing
- Reset values: data=0, valid=0, busy=0, overrun=0, frame_err=0. Synchroniser flops reset to the idle levels: sck per p_sample_rise inverse edge level, cs inactive, mosi=0.
- Input constraint: sck high and low phases ≥3 clk cycles each (transmitter p_clk_div ≥4 satisfies this). mosi must be stable for ≥3 clk around the sample edge. cs setup to the first edge ≥3 clk.
- Latency:
  - Pin sample edge → bit shifted: 3 clk.
  - Final bit's pin edge → valid=1: 4 clk.
  - cs deassert → busy=0 / frame_err pulse: 3 clk.
- overrun and frame_err are exactly one clk wide and are registered.
- ready may be tied high. A word then lives exactly one cycle on valid.

## Structure
- Package spi_pkg: state enum rx_state_t {RX_IDLE, RX_SHIFT} and constant SYNC_STAGES=2. The transmitter may share it.
- Sub-module sync_edge: parameterised synchroniser plus rise/fall detect, instantiated for sck and cs. mosi uses the plain synchroniser path of the same depth.
- The top-level FSM, counter, shift register and output register live in spi_receiver.

## Test plan
- Reset: drive a_rst mid-simulation with valid=1 → all outputs 0 within the same clk, no spurious pulses after release.
- Single word: cs frame carrying 0xA5, ready=1 → one valid with data=0xA5 exactly 4 clk after the 8th sample edge; no error pulses.
- Back-to-back: one cs frame carrying 0x3C then 0xC3, ready=1 → two valids in order with data 0x3C and 0xC3; busy=1 throughout the frame.
- Backpressure: ready=0, send 0x11 then 0x22 → data stays 0x11, one overrun pulse at the second completion. Raising ready then gives one acceptance of 0x11 and valid=0.
- Abort: cs deasserts after 5 bits of 0xFF → frame_err pulse 3 clk later, no valid. The next full frame with 0x81 is received correctly.
- Polarity/edge: p_cs_polar=0, p_sample_rise=0 with matching stimulus of 0x5A → data=0x5A. Toggling sck with cs inactive → no activity.
